// File: rtl/tile_reqmort_sink.sv
// Sinks mesh write/expunge requests into a FIFO, issues each to the bank, then injects one response.
// Push to bank_req takes 1 cycle; ack to in_en takes 1 cycle; sink_full holds off upstream.
module tile_reqmort_sink #(
    parameter int TILE_X = 0,
    parameter int TILE_Y = 0,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         outen,
    input  logic [527:0] reqmort_data,
    input  logic [46:0]  reqmortaddr,
    input  logic [37:0]  reqmort_size,
    input  logic         reqmort_expun,
    output logic         sink_full,
    output logic         bank_req,
    output logic         bank_inv,
    output logic [36:0]  bank_addr,
    output logic [527:0] bank_data,
    output logic [35:0]  bank_msk,
    input  logic         bank_ack,
    output logic         in_en,
    output logic [36:0]  in_addr,
    output logic [37:0]  insize,
    input  logic         resp_rdy,
    output logic         ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] TX = 5'(TILE_X);
    localparam logic [4:0] TY = 5'(TILE_Y);

    typedef struct packed {
        logic [527:0] data;
        logic [36:0]  addr;
        logic [37:0]  size;
        logic         expun;
    } entry_t;

    typedef enum logic [1:0] {IDLE, BANK, RESP} state_t;

    entry_t         mem [DEPTH];
    state_t         state_q;
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q, cnt_d;
    logic           full_q, ovf_q;
    logic           bank_inv_q;
    logic [36:0]    bank_addr_q, in_addr_q;
    logic [527:0]   bank_data_q;
    logic [35:0]    bank_msk_q;
    logic [37:0]    insize_q;

    entry_t in_ent, head;
    logic   route_ok, push, pop;

    always_comb begin
        in_ent   = '{data: reqmort_data, addr: reqmortaddr[36:0],
                     size: reqmort_size, expun: reqmort_expun};
        route_ok = (reqmortaddr[46:42] == TY) && (reqmortaddr[41:37] == TX);
        push     = outen && !full_q && route_ok && !rst;
        pop      = (state_q == RESP) && resp_rdy;
        // With an empty FIFO the incoming request is the head, saving a cycle of latency.
        head     = (cnt_q == '0) ? in_ent : mem[rd_q];
        cnt_d    = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_q] <= in_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            bank_inv_q  <= 1'b0;
            bank_addr_q <= '0;
            bank_data_q <= '0;
            bank_msk_q  <= '0;
            in_addr_q   <= '0;
            insize_q    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == (AW+1)'(DEPTH));
            if (push)
                wr_q <= wr_q + AW'(1);
            if (pop)
                rd_q <= rd_q + AW'(1);
            if (outen && (full_q || !route_ok))
                ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (cnt_q != '0 || push) begin
                    state_q     <= BANK;
                    bank_inv_q  <= head.expun;
                    bank_addr_q <= head.addr;
                    bank_data_q <= head.expun ? '0 : head.data;
                    bank_msk_q  <= head.size[35:0];
                    in_addr_q   <= head.addr;
                    insize_q    <= {head.size[37:36], 36'b0};
                end
                BANK: if (bank_ack) state_q <= RESP;
                RESP: if (resp_rdy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sink_full = full_q;
    assign ovf_err   = ovf_q;
    assign bank_req  = (state_q == BANK);
    assign bank_inv  = bank_inv_q;
    assign bank_addr = bank_addr_q;
    assign bank_data = bank_data_q;
    assign bank_msk  = bank_msk_q;
    assign in_en     = (state_q == RESP) && resp_rdy && !rst;
    assign in_addr   = in_addr_q;
    assign insize    = insize_q;
endmodule

// File: tb/tb_tile_reqmort_sink.sv
// Directed bench for tile_reqmort_sink at TILE_X=1, TILE_Y=2, DEPTH=4.
module tb_tile_reqmort_sink;
    localparam int DEPTH = 4;
    localparam logic [4:0] TX = 5'd1;
    localparam logic [4:0] TY = 5'd2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         outen = 1'b0;
    logic [527:0] reqmort_data = '0;
    logic [46:0]  reqmortaddr = '0;
    logic [37:0]  reqmort_size = '0;
    logic         reqmort_expun = 1'b0;
    logic         sink_full, bank_req, bank_inv, in_en, ovf_err;
    logic [36:0]  bank_addr, in_addr;
    logic [527:0] bank_data;
    logic [35:0]  bank_msk;
    logic [37:0]  insize;
    logic         bank_ack = 1'b0;
    logic         resp_rdy = 1'b0;

    int vecs = 0;
    int errs = 0;

    tile_reqmort_sink #(.TILE_X(1), .TILE_Y(2), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .outen(outen), .reqmort_data(reqmort_data),
        .reqmortaddr(reqmortaddr), .reqmort_size(reqmort_size),
        .reqmort_expun(reqmort_expun), .sink_full(sink_full),
        .bank_req(bank_req), .bank_inv(bank_inv), .bank_addr(bank_addr),
        .bank_data(bank_data), .bank_msk(bank_msk), .bank_ack(bank_ack),
        .in_en(in_en), .in_addr(in_addr), .insize(insize),
        .resp_rdy(resp_rdy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [527:0] obs, input logic [527:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [4:0] y, input logic [4:0] x, input logic [36:0] a,
                             input logic [37:0] sz, input logic ex, input logic [527:0] d);
        outen         = 1'b1;
        reqmortaddr   = {y, x, a};
        reqmort_size  = sz;
        reqmort_expun = ex;
        reqmort_data  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [527:0] d1;
    int got;
    int sent;
    int cyc;

    initial begin
        d1 = {16{33'h1_2345_6789}};
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_full", 528'(sink_full), 528'(0));
        check("rst_bank_req", 528'(bank_req), 528'(0));
        check("rst_in_en", 528'(in_en), 528'(0));
        check("rst_ovf", 528'(ovf_err), 528'(0));
        check("rst_bank_addr", 528'(bank_addr), 528'(0));
        check("rst_insize", 528'(insize), 528'(0));

        // Single write, ack two cycles after bank_req.
        drive_req(TY, TX, 37'h1000, {2'b01, 36'hF}, 1'b0, d1);
        tick();
        outen = 1'b0;
        check("wr_bank_req", 528'(bank_req), 528'(1));
        check("wr_bank_addr", 528'(bank_addr), 528'(37'h1000));
        check("wr_bank_msk", 528'(bank_msk), 528'(36'hF));
        check("wr_bank_inv", 528'(bank_inv), 528'(0));
        check("wr_bank_data", bank_data, d1);
        tick();
        check("wr_bank_hold", 528'(bank_req), 528'(1));
        check("wr_addr_hold", 528'(bank_addr), 528'(37'h1000));
        tick();
        bank_ack = 1'b1;
        resp_rdy = 1'b1;
        #1;
        check("wr_no_in_en_in_bank", 528'(in_en), 528'(0));
        tick();
        bank_ack = 1'b0;
        #1;
        check("wr_in_en", 528'(in_en), 528'(1));
        check("wr_in_addr", 528'(in_addr), 528'(37'h1000));
        check("wr_insize", 528'(insize), 528'({2'b01, 36'b0}));
        check("wr_bank_req_drop", 528'(bank_req), 528'(0));
        tick();
        check("wr_in_en_one_cycle", 528'(in_en), 528'(0));

        // Expunge.
        drive_req(TY, TX, 37'h2000, {2'b10, 36'h3}, 1'b1, d1);
        tick();
        outen = 1'b0;
        check("ex_bank_req", 528'(bank_req), 528'(1));
        check("ex_bank_inv", 528'(bank_inv), 528'(1));
        check("ex_bank_data", bank_data, 528'(0));
        bank_ack = 1'b1;
        tick();
        bank_ack = 1'b0;
        #1;
        check("ex_in_en", 528'(in_en), 528'(1));
        check("ex_in_addr", 528'(in_addr), 528'(37'h2000));
        tick();

        // Misroute: wrong column.
        drive_req(TY, TX + 5'd1, 37'h4000, 38'h0, 1'b0, d1);
        tick();
        outen = 1'b0;
        check("mr_bank_req", 528'(bank_req), 528'(0));
        check("mr_ovf", 528'(ovf_err), 528'(1));
        tick();
        check("mr_bank_req_later", 528'(bank_req), 528'(0));
        check("mr_ovf_sticky", 528'(ovf_err), 528'(1));
        do_reset();
        #1;
        check("mr_ovf_cleared", 528'(ovf_err), 528'(0));

        // Fill and overflow with the bank stalled.
        bank_ack = 1'b0;
        resp_rdy = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            drive_req(TY, TX, 37'h3000 + 37'(i), 38'h0, 1'b0, d1);
            tick();
            check($sformatf("fill_full_%0d", i), 528'(sink_full), 528'(i >= DEPTH - 1));
            check($sformatf("fill_ovf_%0d", i), 528'(ovf_err), 528'(i == DEPTH));
        end
        outen = 1'b0;
        check("fill_head_addr", 528'(bank_addr), 528'(37'h3000));
        bank_ack = 1'b1;
        resp_rdy = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (in_en) begin
                check($sformatf("fill_order_%0d", got), 528'(in_addr), 528'(37'h3000 + 37'(got)));
                got++;
            end
        end
        check("fill_resp_count", 528'(got), 528'(DEPTH));
        check("fill_full_after_drain", 528'(sink_full), 528'(0));
        do_reset();

        // Ordering and pointer wrap with random stalls.
        got = 0;
        sent = 0;
        cyc = 0;
        while (got < 2 * DEPTH + 1 && cyc < 400) begin
            @(posedge clk);
            #1;
            bank_ack = 1'($urandom_range(0, 1));
            resp_rdy = 1'($urandom_range(0, 1));
            if (sent < 2 * DEPTH + 1 && !sink_full && $urandom_range(0, 3) != 0) begin
                drive_req(TY, TX, 37'h5000 + 37'(sent), {2'b01, 36'(sent)}, sent[0], d1);
                sent++;
            end else begin
                outen = 1'b0;
            end
            #1;
            if (in_en) begin
                check($sformatf("ord_%0d", got), 528'(in_addr), 528'(37'h5000 + 37'(got)));
                got++;
            end
            cyc++;
        end
        outen = 1'b0;
        check("ord_resp_count", 528'(got), 528'(2 * DEPTH + 1));
        check("ord_no_ovf", 528'(ovf_err), 528'(0));
        bank_ack = 1'b0;
        resp_rdy = 1'b0;
        tick();

        // Reset while waiting in RESP.
        drive_req(TY, TX, 37'h6000, 38'h0, 1'b0, d1);
        tick();
        outen = 1'b0;
        bank_ack = 1'b1;
        tick();
        bank_ack = 1'b0;
        #1;
        check("rr_no_in_en_stalled", 528'(in_en), 528'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp_rdy = 1'b1;
        #1;
        check("rr_in_en", 528'(in_en), 528'(0));
        check("rr_bank_req", 528'(bank_req), 528'(0));
        check("rr_in_addr", 528'(in_addr), 528'(0));
        tick();
        check("rr_idle_bank_req", 528'(bank_req), 528'(0));
        check("rr_idle_in_en", 528'(in_en), 528'(0));

        // Reset overrides a simultaneous push.
        drive_req(TY, TX, 37'h7000, 38'h0, 1'b0, d1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outen = 1'b0;
        tick();
        check("rov_bank_req", 528'(bank_req), 528'(0));
        check("rov_bank_addr", 528'(bank_addr), 528'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/tile_reqmort_sink.md
TILE_REQMORT_SINK -- requirements
Module: tile_reqmort_sink

Interface
REQ-001 SHALL have parameter TILE_X, default 0, meaning the tile column index of this tile (0..3).
REQ-002 SHALL have parameter TILE_Y, default 0, meaning the tile row index of this tile (0..3).
REQ-003 SHALL have parameter DEPTH, default 4, meaning FIFO entries; legal values are powers of 2 from 2 to 8.
REQ-004 SHALL have port clk, input, 1 bit: the clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port outen, input, 1 bit: a delivered request is valid this cycle.
REQ-007 SHALL have port reqmort_data, input, 528 bits: the line payload.
REQ-008 SHALL have port reqmortaddr, input, 47 bits: {tile_Y[4:0], tile_X[4:0], line address[36:0]}.
REQ-009 SHALL have port reqmort_size, input, 38 bits: {shared, exclusive, phymsk[35:0]}.
REQ-010 SHALL have port reqmort_expun, input, 1 bit: expunge (invalidate) request.
REQ-011 SHALL have port sink_full, output, 1 bit: no free FIFO entry; upstream SHALL NOT assert outen while this is high.
REQ-012 SHALL have port bank_req, output, 1 bit: bank write or invalidate request.
REQ-013 SHALL have port bank_inv, output, 1 bit: 1 = invalidate, 0 = write.
REQ-014 SHALL have port bank_addr, output, 37 bits: line address.
REQ-015 SHALL have port bank_data, output, 528 bits: write data.
REQ-016 SHALL have port bank_msk, output, 36 bits: phymsk.
REQ-017 SHALL have port bank_ack, input, 1 bit: the bank accepted the request this cycle.
REQ-018 SHALL have port in_en, output, 1 bit: response injection strobe to the mesh FIFO.
REQ-019 SHALL have port in_addr, output, 37 bits: response address.
REQ-020 SHALL have port insize, output, 38 bits: response size.
REQ-021 SHALL have port resp_rdy, input, 1 bit: the mesh FIFO can accept an injection.
REQ-022 SHALL have port ovf_err, output, 1 bit: sticky overflow flag.

Function
REQ-023 SHALL capture {data, addr[36:0], size, expun} into the FIFO at the write pointer on every clk edge where outen=1 and sink_full=0.
REQ-024 SHALL drive sink_full = (count == DEPTH), registered, so that it is valid in the same cycle as the FIFO state.
REQ-025 SHALL, when outen=1 and sink_full=1, drop the request, leave the FIFO unchanged and set ovf_err=1; ovf_err SHALL stay set until rst.
REQ-026 SHALL, when reqmortaddr[46:42]!=TILE_Y or reqmortaddr[41:37]!=TILE_X, drop the request without FIFO entry and set ovf_err (misroute).
REQ-027 SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits; a simultaneous push and pop SHALL leave count unchanged.
REQ-028 SHALL run a state machine with states IDLE, BANK, RESP:
- IDLE -> BANK when count>0; the head entry is latched into output registers.
- BANK holds bank_req=1 with stable bank_* outputs until a cycle where bank_ack=1, then goes to RESP.
- RESP holds in_en=0 while resp_rdy=0; in the first cycle with resp_rdy=1 it drives in_en=1 for exactly one cycle, pops the FIFO, and returns to IDLE.
REQ-029 SHALL drive bank_inv = entry expun, bank_msk = size[35:0], and bank_data = 0 when expun=1.
REQ-030 SHALL drive in_addr = entry addr[36:0] and insize = {size[37:36], 36'b0} (ack carries no mask).
REQ-031 SHALL give a minimum latency of 1 cycle from push to bank_req, and 1 cycle from the bank_ack cycle to in_en when resp_rdy=1; throughput is 1 request per 3 cycles.
REQ-032 SHALL treat bank_ack seen outside BANK as ignored, and resp_rdy seen outside RESP as ignored.
REQ-033 SHALL keep requests in arrival order; no reordering between write and expunge requests.

Reset
REQ-034 SHALL, on rst=1, force the state to IDLE, pointers and count to 0, and bank_req, in_en, sink_full and ovf_err to 0; bank_*, in_addr and insize SHALL be 0.
REQ-035 SHALL let rst asserted mid-BANK or mid-RESP abandon the in-flight entry with no in_en pulse; rst SHALL override a simultaneous outen.
REQ-036 SHALL leave FIFO payload storage without reset; only the valid state is reset.

Verification
REQ-037 Single write: outen with addr={TILE_Y,TILE_X,37'h1000}, size phymsk=36'hF, expun=0; bank_ack 2 cycles after bank_req; resp_rdy=1 -> bank_req rises in cycle 1, bank_addr=37'h1000, bank_msk=36'hF, bank_inv=0; in_en=1 for one cycle with in_addr=37'h1000.
REQ-038 Expunge: one expunge request with expun=1 -> bank_inv=1, bank_data=0, followed by a response.
REQ-039 Fill and overflow: DEPTH+1 back-to-back pushes with bank_ack=0 -> sink_full=1 after DEPTH pushes; the extra push is dropped and ovf_err=1.
REQ-040 Ordering and wrap: 2*DEPTH+1 requests with random bank_ack/resp_rdy stalls -> responses appear in issue order and the pointers wrap.
REQ-041 Misroute: one request with addr[41:37]=TILE_X+1 -> no bank_req and ovf_err=1.
REQ-042 Reset in RESP: rst asserted during RESP with resp_rdy=0 -> in the next cycle count=0, no in_en pulse, and state is IDLE.
